// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a} for hex digits and the "all off" codes.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // True when digit idx and every digit to its left are zero; digit 0 always lights.
    function automatic logic lead_zero(input logic [15:0] val, input logic [1:0] idx);
        case (idx)
            2'd3:    return (val[15:12] == 4'h0);
            2'd2:    return (val[15:8] == 8'h00);
            2'd1:    return (val[15:4] == 12'h000);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver; the value is captured
// once per frame into a shadow register so a scan never shows torn digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b0
) (
    input  logic        clk_pi,
    input  logic        reset_pi,
    input  logic [15:0] display_num_pi,
    input  logic        blank_pi,
    output logic [3:0]  an_po,
    output logic [6:0]  seg_po,
    output logic        dp_po
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       dig_idx;
    logic [15:0]      shadow;
    logic             load_pend;
    logic             tick;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;
    logic             dark;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;

    assign tick   = (div_cnt == DIV_LAST);
    assign nibble = shadow[{dig_idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Stay dark until the first capture so stale zeros never flash after reset.
    assign dark = blank_pi | load_pend | (BLANK_LZ & lead_zero(shadow, dig_idx));

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        if (!dark) begin
            an_next  = ~(4'b0001 << dig_idx);
            seg_next = seg_dec;
        end
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            div_cnt   <= '0;
            dig_idx   <= 2'd0;
            shadow    <= 16'h0000;
            load_pend <= 1'b1;
            an_po     <= AN_OFF;
            seg_po    <= SEG_OFF;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                dig_idx <= dig_idx + 1'b1;
            if (load_pend || (tick && dig_idx == 2'd3))
                shadow <= display_num_pi;
            load_pend <= 1'b0;
            an_po     <= an_next;
            seg_po    <= seg_next;
        end
    end

    assign dp_po = 1'b1;

endmodule
